// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED peripheral: bus command codes, output mode
// encoding and the field layout of the READ_CFG readback word.
package led_ctrl_pkg;

  localparam logic [5:0] CMD_NOP         = 6'b000000;
  localparam logic [5:0] CMD_WRITE_STATE = 6'b000001;
  localparam logic [5:0] CMD_SET_MODE    = 6'b000010;
  localparam logic [5:0] CMD_SET_DUTY    = 6'b000011;
  localparam logic [5:0] CMD_SET_PERIOD  = 6'b000100;
  localparam logic [5:0] CMD_READ_STATE  = 6'b000101;
  localparam logic [5:0] CMD_READ_CFG    = 6'b000110;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_e;

  // READ_CFG word: duty at [15:8], phase at [2], mode at [1:0]
  localparam int CFG_MODE_LSB  = 0;
  localparam int CFG_PHASE_BIT = 2;
  localparam int CFG_DUTY_LSB  = 8;

  // Codes 1..6 are the only ones this block acts on; NOP and the rest are ignored.
  function automatic logic cmd_defined(input logic [5:0] c);
    return (c != CMD_NOP) && (c <= CMD_READ_CFG);
  endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Device/command bus as seen by one peripheral. The master drives the select,
// command and write data; the peripheral returns its registered readback.
interface led_ctrl_if;
  logic [4:0]  device;
  logic [5:0]  command;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output device, output command, output data_in, input data_out);
  modport slave  (input device, input command, input data_in, output data_out);
endinterface

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every `period` clocks. Periods of 0 and
// 1 both mean "tick every cycle". The tick is withheld in a clear cycle so a
// reconfiguration never coincides with a phase step.
module led_tick_gen #(
  parameter int TICK_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [TICK_BITS-1:0] period,
  output logic                 tick
);

  logic [TICK_BITS-1:0] count_q, count_d;
  logic                 at_end;

  assign at_end = (period <= TICK_BITS'(1)) || (count_q == period - TICK_BITS'(1));
  assign tick   = at_end && !clear;

  // Next count: restart on clear or at the end of a period, otherwise advance.
  always_comb begin
    count_d = count_q + TICK_BITS'(1);
    if (clear || at_end) count_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/led_ctrl.sv
// LED peripheral on the shared device/command bus. Holds the configuration
// registers, the free-running PWM counter and the rotate register, and muxes
// them onto a registered LED output according to the selected mode.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int          NUM_LEDS       = 8,
  parameter int          PWM_BITS       = 8,
  parameter int          TICK_BITS      = 24,
  parameter int unsigned DEFAULT_PERIOD = 12_500_000,
  parameter logic [4:0]  DEVICE_ID      = 5'b00000
) (
  input  logic                clk,
  input  logic                reset,
  led_ctrl_if.slave           bus,
  output logic [NUM_LEDS-1:0] leds
);

  localparam logic [TICK_BITS-1:0] PERIOD_RST = TICK_BITS'(DEFAULT_PERIOD);

  logic [NUM_LEDS-1:0]  led_data_q, led_data_d;
  logic [NUM_LEDS-1:0]  rot_q, rot_d;
  mode_e                mode_q, mode_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic [TICK_BITS-1:0] period_q, period_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic                 phase_q, phase_d;
  logic [31:0]          data_out_q, data_out_d;
  logic [NUM_LEDS-1:0]  leds_q, leds_d;

  logic accept;
  logic wr_state, set_mode, set_duty, set_period, rd_state, rd_cfg;
  logic tick, tick_clear, pwm_on;
  logic [NUM_LEDS-1:0] rot_next;
  logic [31:0] cfg_word;

  assign accept     = (bus.device == DEVICE_ID) && cmd_defined(bus.command);
  assign wr_state   = accept && (bus.command == CMD_WRITE_STATE);
  assign set_mode   = accept && (bus.command == CMD_SET_MODE);
  assign set_duty   = accept && (bus.command == CMD_SET_DUTY);
  assign set_period = accept && (bus.command == CMD_SET_PERIOD);
  assign rd_state   = accept && (bus.command == CMD_READ_STATE);
  assign rd_cfg     = accept && (bus.command == CMD_READ_CFG);

  // A new mode or period restarts the prescaler and swallows that cycle's tick.
  assign tick_clear = set_mode || set_period;

  led_tick_gen #(.TICK_BITS(TICK_BITS)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .period (period_q),
    .tick   (tick)
  );

  // Shift/or form keeps the single-LED case legal: it degenerates to no change.
  assign rot_next = (rot_q << 1) | (rot_q >> (NUM_LEDS - 1));
  assign pwm_on   = (pwm_cnt_q < duty_q);

  // Readback word for READ_CFG.
  always_comb begin
    cfg_word = '0;
    cfg_word[CFG_DUTY_LSB +: 8]  = 8'(duty_q);
    cfg_word[CFG_PHASE_BIT]      = phase_q;
    cfg_word[CFG_MODE_LSB +: 2]  = mode_q;
  end

  // Next-state for all configuration and run-time registers; loads are applied
  // after the tick updates so a command in a tick cycle wins.
  always_comb begin
    led_data_d = led_data_q;
    rot_d      = rot_q;
    mode_d     = mode_q;
    duty_d     = duty_q;
    period_d   = period_q;
    phase_d    = phase_q;
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    data_out_d = data_out_q;

    if (tick) begin
      phase_d = ~phase_q;
      if (mode_q == MODE_ROTATE) rot_d = rot_next;
    end

    if (wr_state) begin
      led_data_d = bus.data_in[NUM_LEDS-1:0];
      rot_d      = bus.data_in[NUM_LEDS-1:0];
    end
    if (set_mode) begin
      mode_d  = mode_e'(bus.data_in[1:0]);
      phase_d = 1'b0;
      rot_d   = led_data_q;
    end
    if (set_duty)   duty_d     = bus.data_in[PWM_BITS-1:0];
    if (set_period) period_d   = bus.data_in[TICK_BITS-1:0];
    if (rd_state)   data_out_d = 32'(led_data_q);
    if (rd_cfg)     data_out_d = cfg_word;
  end

  // Output mux, evaluated on pre-edge register values.
  always_comb begin
    leds_d = '0;
    case (mode_q)
      MODE_STATIC: leds_d = led_data_q;
      MODE_BLINK:  leds_d = phase_q ? led_data_q : '0;
      MODE_PWM:    leds_d = pwm_on ? led_data_q : '0;
      MODE_ROTATE: leds_d = rot_q;
      default:     leds_d = '0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_data_q <= '0;
      rot_q      <= '0;
      mode_q     <= MODE_STATIC;
      duty_q     <= '1;
      period_q   <= PERIOD_RST;
      pwm_cnt_q  <= '0;
      phase_q    <= 1'b0;
      data_out_q <= '0;
      leds_q     <= '0;
    end else begin
      led_data_q <= led_data_d;
      rot_q      <= rot_d;
      mode_q     <= mode_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      pwm_cnt_q  <= pwm_cnt_d;
      phase_q    <= phase_d;
      data_out_q <= data_out_d;
      leds_q     <= leds_d;
    end
  end

  assign leds         = leds_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: an 8-LED default instance and a 32-LED /
// 4-bit PWM / 8-bit tick instance side by side on their own bus interfaces.
module tb_led_ctrl;
  import led_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [7:0]  leds8;
  logic [31:0] leds32;

  led_ctrl_if bus8();
  led_ctrl_if bus32();

  led_ctrl u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave),
    .leds  (leds8)
  );

  led_ctrl #(
    .NUM_LEDS       (32),
    .PWM_BITS       (4),
    .TICK_BITS      (8),
    .DEFAULT_PERIOD (200),
    .DEVICE_ID      (5'b00011)
  ) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave),
    .leds  (leds32)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  dev;
    logic [5:0]  cmd;
    logic [31:0] din;
    logic [7:0]  exp_leds;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one command for exactly one rising edge, then return the bus to NOP.
  task automatic issue(input bit sel32, input logic [4:0] dev, input logic [5:0] c,
                       input logic [31:0] d);
    if (sel32) begin
      bus32.device = dev; bus32.command = c; bus32.data_in = d;
    end else begin
      bus8.device = dev; bus8.command = c; bus8.data_in = d;
    end
    @(negedge clk);
    if (sel32) bus32.command = CMD_NOP;
    else       bus8.command  = CMD_NOP;
  endtask

  initial begin
    logic [7:0]  e8;
    logic [31:0] e32;
    int on_cnt, bad_cnt;

    vecs[0]  = '{5'd0, CMD_READ_CFG,    32'h0,        8'h00, 32'h0000FF00};
    vecs[1]  = '{5'd1, CMD_WRITE_STATE, 32'hA5,       8'h00, 32'h0000FF00};
    vecs[2]  = '{5'd0, CMD_WRITE_STATE, 32'hA5,       8'hA5, 32'h0000FF00};
    vecs[3]  = '{5'd0, CMD_NOP,         32'hFF,       8'hA5, 32'h0000FF00};
    vecs[4]  = '{5'd0, 6'd7,            32'hFF,       8'hA5, 32'h0000FF00};
    vecs[5]  = '{5'd0, 6'h3F,           32'hFF,       8'hA5, 32'h0000FF00};
    vecs[6]  = '{5'd0, CMD_READ_STATE,  32'h0,        8'hA5, 32'h000000A5};
    vecs[7]  = '{5'd0, CMD_WRITE_STATE, 32'hFFFF_FF3C, 8'h3C, 32'h000000A5};
    vecs[8]  = '{5'd0, CMD_READ_STATE,  32'h0,        8'h3C, 32'h0000003C};
    vecs[9]  = '{5'd0, CMD_SET_DUTY,    32'h140,      8'h3C, 32'h0000003C};
    vecs[10] = '{5'd0, CMD_READ_CFG,    32'h0,        8'h3C, 32'h00004000};
    vecs[11] = '{5'd2, CMD_READ_STATE,  32'h0,        8'h3C, 32'h00004000};

    reset = 1'b1;
    bus8.device  = 5'd0; bus8.command  = CMD_NOP; bus8.data_in  = '0;
    bus32.device = 5'd0; bus32.command = CMD_NOP; bus32.data_in = '0;
    step(); step();
    chk("reset_leds8",  32'(leds8), 32'h0);
    chk("reset_dout8",  bus8.data_out, 32'h0);
    chk("reset_leds32", leds32, 32'h0);
    reset = 1'b0;

    // Single-cycle commands in STATIC mode
    for (int i = 0; i < 12; i++) begin
      issue(1'b0, vecs[i].dev, vecs[i].cmd, vecs[i].din);
      step();
      chk($sformatf("vec%0d_leds", i), 32'(leds8), 32'(vecs[i].exp_leds));
      chk($sformatf("vec%0d_dout", i), bus8.data_out, vecs[i].exp_dout);
    end

    // BLINK, period 4: 0x00 for four cycles then 0xFF for four
    issue(1'b0, 5'd0, CMD_WRITE_STATE, 32'hFF);
    issue(1'b0, 5'd0, CMD_SET_PERIOD, 32'd4);
    issue(1'b0, 5'd0, CMD_SET_MODE, 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("blink_%0d", k), 32'(leds8), (((k - 1) / 4) % 2 == 1) ? 32'hFF : 32'h00);
    end
    issue(1'b0, 5'd0, CMD_READ_CFG, 32'h0);
    chk("blink_cfg", bus8.data_out & 32'hFFFF_FF03, 32'h00004001);

    // PWM: count on-cycles over a full 256-cycle window for three duties
    issue(1'b0, 5'd0, CMD_WRITE_STATE, 32'h0F);
    issue(1'b0, 5'd0, CMD_SET_DUTY, 32'd64);
    issue(1'b0, 5'd0, CMD_SET_MODE, 32'd2);
    for (int d = 0; d < 3; d++) begin
      if (d == 1) issue(1'b0, 5'd0, CMD_SET_DUTY, 32'd0);
      if (d == 2) issue(1'b0, 5'd0, CMD_SET_DUTY, 32'd255);
      step();
      on_cnt = 0; bad_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        if (leds8 == 8'h0F) on_cnt++;
        else if (leds8 != 8'h00) bad_cnt++;
        step();
      end
      chk($sformatf("pwm_on_%0d", d), 32'(on_cnt), (d == 0) ? 32'd64 : (d == 1) ? 32'd0 : 32'd255);
      chk($sformatf("pwm_bad_%0d", d), 32'(bad_cnt), 32'd0);
    end

    // ROTATE with a tick every cycle
    issue(1'b0, 5'd0, CMD_WRITE_STATE, 32'h81);
    issue(1'b0, 5'd0, CMD_SET_PERIOD, 32'd1);
    issue(1'b0, 5'd0, CMD_SET_MODE, 32'd3);
    e8 = 8'h81;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("rot_%0d", k), 32'(leds8), 32'(e8));
      e8 = {e8[6:0], e8[7]};
    end
    // A load on a tick cycle wins over the rotate
    issue(1'b0, 5'd0, CMD_WRITE_STATE, 32'h01);
    step();
    chk("rot_load", 32'(leds8), 32'h01);
    step();
    chk("rot_after_load", 32'(leds8), 32'h02);
    // SET_PERIOD on a tick cycle holds the rotate for that cycle
    issue(1'b0, 5'd0, CMD_SET_PERIOD, 32'd1);
    step();
    chk("rot_period_hold", 32'(leds8), 32'h04);
    step();
    chk("rot_period_resume", 32'(leds8), 32'h08);

    // Readback hold, then asynchronous reset in the middle of it
    issue(1'b0, 5'd0, CMD_WRITE_STATE, 32'h3C);
    issue(1'b0, 5'd0, CMD_READ_STATE, 32'h0);
    chk("rd_after_wr", bus8.data_out, 32'h0000003C);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("rd_hold_%0d", i), bus8.data_out, 32'h0000003C);
    end
    reset = 1'b1;
    #1;
    chk("async_rst_dout", bus8.data_out, 32'h0);
    chk("async_rst_leds", 32'(leds8), 32'h0);
    step();
    reset = 1'b0;
    issue(1'b0, 5'd0, CMD_READ_CFG, 32'h0);
    chk("post_rst_cfg", bus8.data_out, 32'h0000FF00);
    issue(1'b0, 5'd0, CMD_WRITE_STATE, 32'h55);
    step();
    chk("post_rst_static", 32'(leds8), 32'h55);

    // Wide instance: 32 LEDs, 4-bit PWM, 8-bit tick, device 3
    issue(1'b1, 5'd3, CMD_WRITE_STATE, 32'hDEADBEEF);
    step();
    chk("w32_write", leds32, 32'hDEADBEEF);
    issue(1'b1, 5'd0, CMD_WRITE_STATE, 32'h12345678);
    step();
    chk("w32_wrong_dev", leds32, 32'hDEADBEEF);
    issue(1'b1, 5'd3, CMD_SET_PERIOD, 32'd0);
    issue(1'b1, 5'd3, CMD_SET_MODE, 32'd3);
    e32 = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("w32_rot_%0d", k), leds32, e32);
      e32 = {e32[30:0], e32[31]};
    end
    issue(1'b1, 5'd3, CMD_READ_CFG, 32'h0);
    chk("w32_cfg", bus32.data_out & 32'hFFFF_FF03, 32'h00000F03);
    issue(1'b1, 5'd3, CMD_SET_MODE, 32'd2);
    step();
    on_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (leds32 == 32'hDEADBEEF) on_cnt++;
      else if (leds32 != 32'h0) bad_cnt++;
      step();
    end
    chk("w32_pwm_on", 32'(on_cnt), 32'd15);
    chk("w32_pwm_bad", 32'(bad_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
